riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// ============================================================================
// Module  : riscv_mem_arbiter
// Brief   : Two-port (fetch/data) arbiter onto a single-port memory with one
//           request outstanding and bounded data priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_arbiter #(
  parameter int N_param    = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_DGRANT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [N_param-1:0]   if_addr,
  output logic                 if_rsp_valid,
  output logic [N_param-1:0]   if_rsp_data,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic [N_param-1:0]   d_addr,
  input  logic                 d_we,
  input  logic [N_param-1:0]   d_wdata,
  input  logic [N_param/8-1:0] d_wstrb,
  output logic                 d_rsp_valid,
  output logic [N_param-1:0]   d_rsp_data,
  output logic                 mem_en,
  output logic [N_param/8-1:0] mem_we,
  output logic [N_param-1:0]   mem_addr,
  output logic [N_param-1:0]   mem_wdata,
  input  logic [N_param-1:0]   mem_rdata,
  output logic                 busy
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_wait  = 2'd2;
  localparam logic [1:0] c_resp  = 2'd3;

  localparam bit         c_single      = (MEM_LAT == 1);
  localparam int         c_wait_cycles = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam logic [2:0] c_wait_init   = c_wait_cycles[2:0];
  localparam logic [3:0] c_max_dgrant  = MAX_DGRANT[3:0];

  logic [1:0]           r_state;
  logic [3:0]           r_dcount;
  logic [2:0]           r_lat_cnt;
  logic [N_param-1:0]   r_addr;
  logic [N_param-1:0]   r_wdata;
  logic [N_param/8-1:0] r_wstrb;
  logic                 r_we;
  logic                 r_src_d;
  logic [N_param-1:0]   r_if_rsp_data;
  logic [N_param-1:0]   r_d_rsp_data;

  logic w_idle;
  logic w_issue;
  logic w_grant_d;
  logic w_grant_f;
  logic w_sample;

  assign w_idle  = (r_state == c_idle);
  assign w_issue = (r_state == c_issue);

  // Readies are combinational, so gate them with reset to keep them low while
  // the arbiter is held in reset.
  assign w_grant_d = reset & w_idle & d_req_valid
                   & ~(if_req_valid & (r_dcount == c_max_dgrant));
  assign w_grant_f = reset & w_idle & if_req_valid & ~w_grant_d;

  // mem_rdata is valid on the edge that leaves the last latency cycle.
  assign w_sample = (w_issue & c_single)
                  | ((r_state == c_wait) & (r_lat_cnt == 3'd0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_idle;
      r_dcount      <= 4'd0;
      r_lat_cnt     <= 3'd0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_we          <= 1'b0;
      r_src_d       <= 1'b0;
      r_if_rsp_data <= '0;
      r_d_rsp_data  <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_grant_d || w_grant_f) begin
            r_state <= c_issue;
            r_src_d <= w_grant_d;
            r_addr  <= w_grant_d ? d_addr : if_addr;
            r_we    <= w_grant_d & d_we;
            r_wdata <= w_grant_d ? d_wdata : '0;
            r_wstrb <= w_grant_d ? d_wstrb : '0;
            if (w_grant_d) begin
              if (r_dcount != c_max_dgrant) r_dcount <= r_dcount + 4'd1;
            end else begin
              r_dcount <= 4'd0;
            end
          end
        end
        c_issue: begin
          r_state   <= c_single ? c_resp : c_wait;
          r_lat_cnt <= c_wait_init;
        end
        c_wait: begin
          if (r_lat_cnt == 3'd0) r_state <= c_resp;
          else r_lat_cnt <= r_lat_cnt - 3'd1;
        end
        default: r_state <= c_idle;
      endcase

      if (w_sample) begin
        if (r_src_d) r_d_rsp_data <= r_we ? '0 : mem_rdata;
        else r_if_rsp_data <= mem_rdata;
      end
    end
  end

  assign if_req_ready = w_grant_f;
  assign d_req_ready  = w_grant_d;
  assign mem_en       = w_issue;
  assign mem_we       = (w_issue & r_we) ? r_wstrb : '0;
  assign mem_addr     = w_issue ? r_addr : '0;
  assign mem_wdata    = w_issue ? r_wdata : '0;
  assign if_rsp_valid = (r_state == c_resp) & ~r_src_d;
  assign d_rsp_valid  = (r_state == c_resp) & r_src_d;
  assign if_rsp_data  = r_if_rsp_data;
  assign d_rsp_data   = r_d_rsp_data;
  assign busy         = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
// ============================================================================
// Module  : tb_riscv_mem_arbiter
// Brief   : Directed self-checking bench; instance a uses MEM_LAT=1, b MEM_LAT=3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req_valid, d_req_valid, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;

  logic        if_req_ready_a, if_rsp_valid_a, d_req_ready_a, d_rsp_valid_a, mem_en_a, busy_a;
  logic [31:0] if_rsp_data_a, d_rsp_data_a, mem_addr_a, mem_wdata_a;
  logic [3:0]  mem_we_a;
  logic        if_req_ready_b, if_rsp_valid_b, d_req_ready_b, d_rsp_valid_b, mem_en_b, busy_b;
  logic [31:0] if_rsp_data_b, d_rsp_data_b, mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_we_b;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_mem_arbiter #(.N_param(32), .MEM_LAT(1), .MAX_DGRANT(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready_a), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid_a), .if_rsp_data(if_rsp_data_a),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_a), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid_a), .d_rsp_data(d_rsp_data_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata), .busy(busy_a)
  );

  riscv_mem_arbiter #(.N_param(32), .MEM_LAT(3), .MAX_DGRANT(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready_b), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid_b), .if_rsp_data(if_rsp_data_b),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_b), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid_b), .d_rsp_data(d_rsp_data_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Holds reset for two cycles; returns at a falling edge with reset released.
  task automatic do_reset();
    reset = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req_valid = 1'b1; d_req_valid = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({if_req_ready_a, d_req_ready_a, if_req_ready_b, d_req_ready_b} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0000",
        {if_req_ready_a, d_req_ready_a, if_req_ready_b, d_req_ready_b});
    end
    n_checks++;
    if ({busy_a, mem_en_a, if_rsp_valid_a, d_rsp_valid_a} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000",
        {busy_a, mem_en_a, if_rsp_valid_a, d_rsp_valid_a});
    end
    n_checks++;
    if ({mem_we_a, mem_addr_a, mem_wdata_a, if_rsp_data_a, d_rsp_data_a} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h expected 0", mem_addr_a, if_rsp_data_a, d_rsp_data_a);
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h0000_0BAD;
    #1;
    n_checks++;
    if (if_req_ready_a !== 1'b1 || d_req_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL fetch_ready: got if=%b d=%b expected if=1 d=0", if_req_ready_a, d_req_ready_a);
    end
    @(negedge clk); if_req_valid = 1'b0; mem_rdata = 32'h0000_0013; #1;
    n_checks++;
    if (mem_en_a !== 1'b1 || mem_addr_a !== 32'h10 || mem_we_a !== 4'b0) begin
      n_fail++; $display("FAIL fetch_issue: got en=%b addr=%h we=%b expected en=1 addr=10 we=0", mem_en_a, mem_addr_a, mem_we_a);
    end
    @(negedge clk); mem_rdata = 32'h0000_0077; #1;
    n_checks++;
    if (if_rsp_valid_a !== 1'b1 || if_rsp_data_a !== 32'h13 || d_rsp_valid_a !== 1'b0 || mem_en_a !== 1'b0) begin
      n_fail++; $display("FAIL fetch_resp: got v=%b data=%h dv=%b en=%b expected v=1 data=13 dv=0 en=0",
        if_rsp_valid_a, if_rsp_data_a, d_rsp_valid_a, mem_en_a);
    end
    @(negedge clk); #1;
    n_checks++;
    if (if_rsp_valid_a !== 1'b0 || if_rsp_data_a !== 32'h13 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL fetch_hold: got v=%b data=%h busy=%b expected v=0 data=13 busy=0",
        if_rsp_valid_a, if_rsp_data_a, busy_a);
    end
  endtask

  task automatic test_store();
    do_reset();
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    #1;
    n_checks++;
    if (d_req_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL store_ready: got %b expected 1", d_req_ready_a);
    end
    @(negedge clk); d_req_valid = 1'b0; mem_rdata = 32'h5555_5555; #1;
    n_checks++;
    if (mem_en_a !== 1'b1 || mem_we_a !== 4'b0011 || mem_wdata_a !== 32'hDEAD_BEEF || mem_addr_a !== 32'h100) begin
      n_fail++; $display("FAIL store_issue: got en=%b we=%b wdata=%h addr=%h expected 1/0011/deadbeef/100",
        mem_en_a, mem_we_a, mem_wdata_a, mem_addr_a);
    end
    @(negedge clk); #1;
    n_checks++;
    if (d_rsp_valid_a !== 1'b1 || d_rsp_data_a !== 32'h0 || if_rsp_valid_a !== 1'b0 || mem_we_a !== 4'b0) begin
      n_fail++; $display("FAIL store_resp: got dv=%b data=%h iv=%b we=%b expected 1/0/0/0",
        d_rsp_valid_a, d_rsp_data_a, if_rsp_valid_a, mem_we_a);
    end
  endtask

  task automatic test_arbitration();
    logic [9:0] exp_d;
    exp_d = 10'b0111101111;  // bit g set: grant g goes to data
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h20; d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    for (int g = 0; g < 10; g++) begin
      int waited;
      bit got, was_d;
      waited = 0; got = 1'b0; was_d = 1'b0;
      while (!got && waited < 8) begin
        #1;
        if (d_req_ready_a || if_req_ready_a) begin
          got = 1'b1; was_d = d_req_ready_a;
          n_checks++;
          if (d_req_ready_a && if_req_ready_a) begin
            n_fail++; $display("FAIL arb_excl: grant %0d both readies high", g);
          end
        end else begin
          waited++;
        end
        @(negedge clk);
      end
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL arb_timeout: grant %0d got none expected a grant", g);
      end
      n_checks++;
      if (was_d !== exp_d[g]) begin
        n_fail++; $display("FAIL arb_order: grant %0d got data=%b expected data=%b", g, was_d, exp_d[g]);
      end
      n_checks++;
      if (waited != ((g == 0) ? 0 : 2)) begin
        n_fail++; $display("FAIL arb_spacing: grant %0d got %0d idle cycles expected %0d", g, waited, (g == 0) ? 0 : 2);
      end
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_rdata = 32'hA0;
    #1;
    n_checks++;
    if (d_req_ready_b !== 1'b1) begin
      n_fail++; $display("FAIL lat_ready: got %b expected 1", d_req_ready_b);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); mem_rdata = 32'hA0 + k; #1;
      if (k == 1) begin
        n_checks++;
        if (mem_en_b !== 1'b1 || mem_addr_b !== 32'h200 || d_req_ready_b !== 1'b0) begin
          n_fail++; $display("FAIL lat_issue: got en=%b addr=%h rdy=%b expected 1/200/0", mem_en_b, mem_addr_b, d_req_ready_b);
        end
      end else if (k <= 3) begin
        n_checks++;
        if (mem_en_b !== 1'b0 || d_rsp_valid_b !== 1'b0 || d_req_ready_b !== 1'b0 || busy_b !== 1'b1) begin
          n_fail++; $display("FAIL lat_wait: T+%0d got en=%b dv=%b rdy=%b busy=%b expected 0/0/0/1",
            k, mem_en_b, d_rsp_valid_b, d_req_ready_b, busy_b);
        end
      end else if (k == 4) begin
        n_checks++;
        if (d_rsp_valid_b !== 1'b1 || d_rsp_data_b !== 32'hA3 || d_req_ready_b !== 1'b0) begin
          n_fail++; $display("FAIL lat_resp: got dv=%b data=%h rdy=%b expected 1/a3/0", d_rsp_valid_b, d_rsp_data_b, d_req_ready_b);
        end
      end else begin
        n_checks++;
        if (d_req_ready_b !== 1'b1 || d_rsp_valid_b !== 1'b0) begin
          n_fail++; $display("FAIL lat_next: got rdy=%b dv=%b expected 1/0", d_req_ready_b, d_rsp_valid_b);
        end
      end
    end
    @(negedge clk); d_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_d;
    int seen;
    int accepts;
    int cyc;
    exp_d = 5'b01111;
    do_reset();
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h80; if_addr = 32'h40;
    accepts = 0; cyc = 0;
    // Four data loads bring dcount to MAX_DGRANT before the abort.
    while (accepts < 4 && cyc < 40) begin
      #1;
      if (d_req_ready_b) accepts++;
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (accepts != 4) begin
      n_fail++; $display("FAIL rmid_setup: got %0d accepts expected 4", accepts);
    end
    d_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; if_req_valid = 1'b1; #1;
    n_checks++;
    if ({busy_b, mem_en_b, if_rsp_valid_b, d_rsp_valid_b, if_req_ready_b, d_req_ready_b} !== 6'b0) begin
      n_fail++; $display("FAIL rmid_drop: got %b expected 000000",
        {busy_b, mem_en_b, if_rsp_valid_b, d_rsp_valid_b, if_req_ready_b, d_req_ready_b});
    end
    @(negedge clk); if_req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (mem_en_b || if_rsp_valid_b || d_rsp_valid_b) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rmid_ghost: got %0d active cycles expected 0", seen);
    end
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    for (int g = 0; g < 5; g++) begin
      int waited;
      bit got, was_d;
      waited = 0; got = 1'b0; was_d = 1'b0;
      while (!got && waited < 10) begin
        #1;
        if (d_req_ready_b || if_req_ready_b) begin
          got = 1'b1; was_d = d_req_ready_b;
        end else begin
          waited++;
        end
        @(negedge clk);
      end
      n_checks++;
      if (!got || was_d !== exp_d[g]) begin
        n_fail++; $display("FAIL rmid_order: grant %0d got found=%b data=%b expected found=1 data=%b", g, got, was_d, exp_d[g]);
      end
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  task automatic test_zero_strobe();
    do_reset();
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'b0000;
    if_req_valid = 1'b1; if_addr = 32'h400;
    #1;
    n_checks++;
    if (d_req_ready_a !== 1'b1 || if_req_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL zs_grant: got d=%b if=%b expected d=1 if=0", d_req_ready_a, if_req_ready_a);
    end
    @(negedge clk); d_req_valid = 1'b0; #1;
    n_checks++;
    if (mem_en_a !== 1'b1 || mem_we_a !== 4'b0000 || mem_addr_a !== 32'h300) begin
      n_fail++; $display("FAIL zs_issue: got en=%b we=%b addr=%h expected 1/0000/300", mem_en_a, mem_we_a, mem_addr_a);
    end
    @(negedge clk); #1;
    n_checks++;
    if (d_rsp_valid_a !== 1'b1 || d_rsp_data_a !== 32'h0 || if_req_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL zs_resp: got dv=%b data=%h ifrdy=%b expected 1/0/0", d_rsp_valid_a, d_rsp_data_a, if_req_ready_a);
    end
    @(negedge clk); #1;
    n_checks++;
    if (if_req_ready_a !== 1'b1 || d_rsp_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL zs_fetch: got ifrdy=%b dv=%b expected 1/0", if_req_ready_a, d_rsp_valid_a);
    end
    @(negedge clk); if_req_valid = 1'b0; #1;
    n_checks++;
    if (mem_en_a !== 1'b1 || mem_addr_a !== 32'h400 || mem_we_a !== 4'b0) begin
      n_fail++; $display("FAIL zs_fissue: got en=%b addr=%h we=%b expected 1/400/0", mem_en_a, mem_addr_a, mem_we_a);
    end
  endtask

  initial begin
    reset = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_store();
    test_arbitration();
    test_latency();
    test_reset_mid();
    test_zero_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
